// File: rtl/main.sv
// Four-approach round-robin traffic-light controller (A, B, C, D).
// Each served approach runs through green, yellow and an all-red clearance.
// The next approach is the first one after the current one, in A-B-C-D order,
// whose sensor bit is set.
module main #(
  parameter int unsigned MIN_GREEN = 50,
  parameter int unsigned MAX_GREEN = 300,
  parameter int unsigned YELLOW_T  = 30,
  parameter int unsigned ALLRED_T  = 10
) (
  input  logic       clk,
  input  logic       arstN,  // synchronous, active-high despite the name
  input  logic [3:0] sensor,
  output logic [2:0] tl_sig_arr [0:3]
);

  localparam int unsigned CntW = $clog2(MAX_GREEN + 1);

  localparam logic [2:0] LampGreen  = 3'b001;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampRed    = 3'b100;

  typedef enum logic [1:0] {StGreen, StYellow, StAllRed} phase_e;

  phase_e          phase_q, phase_d;
  logic [1:0]      cur_q, cur_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [3:0] cur_onehot;
  logic       other_req;
  logic [1:0] next_appr;
  logic       found;

  // Request decode and round-robin search for the next approach to serve
  always_comb begin
    cur_onehot = 4'b0001 << cur_q;
    other_req  = |(sensor & ~cur_onehot);
    next_appr  = cur_q + 2'd1;
    found      = 1'b0;
    for (int i = 1; i < 4; i++) begin
      logic [1:0] idx;
      idx = cur_q + 2'(i);
      if (!found && sensor[idx]) begin
        next_appr = idx;
        found     = 1'b1;
      end
    end
  end

  // State register: phase, served approach and cycle counter
  always_ff @(posedge clk) begin
    if (arstN) begin
      phase_q <= StGreen;
      cur_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter clears on every phase change
  always_comb begin
    phase_d = phase_q;
    cur_d   = cur_q;
    // Saturate so an idle green can last forever without wrapping
    cnt_d   = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    unique case (phase_q)
      StGreen: begin
        if (other_req &&
            ((!sensor[cur_q] && (cnt_q >= CntW'(MIN_GREEN - 1))) ||
             (cnt_q >= CntW'(MAX_GREEN - 1)))) begin
          phase_d = StYellow;
          cnt_d   = '0;
        end
      end
      StYellow: begin
        if (cnt_q >= CntW'(YELLOW_T - 1)) begin
          phase_d = StAllRed;
          cnt_d   = '0;
        end
      end
      StAllRed: begin
        if (cnt_q >= CntW'(ALLRED_T - 1)) begin
          phase_d = StGreen;
          cur_d   = next_appr;
          cnt_d   = '0;
        end
      end
      default: begin
        phase_d = StGreen;
        cnt_d   = '0;
      end
    endcase
  end

  // Lamp outputs decoded from state only: only the served approach can be non-red
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      tl_sig_arr[i] = LampRed;
      if (cur_q == 2'(i)) begin
        if (phase_q == StGreen)  tl_sig_arr[i] = LampGreen;
        if (phase_q == StYellow) tl_sig_arr[i] = LampYellow;
      end
    end
  end

endmodule

// File: tb/tb_main.sv
// Directed bench for the traffic-light controller. Lamps are packed as
// {D, C, B, A} and checked every cycle, 1 time unit after the rising edge.
module tb_main;

  logic       clk;
  logic       arstN;
  logic [3:0] sensor;
  logic [2:0] tl_sig_arr [0:3];

  int n_cmp;
  int n_err;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  localparam logic [11:0] AG = {R, R, R, G};
  localparam logic [11:0] AY = {R, R, R, Y};
  localparam logic [11:0] BG = {R, R, G, R};
  localparam logic [11:0] BY = {R, R, Y, R};
  localparam logic [11:0] CG = {R, G, R, R};
  localparam logic [11:0] CY = {R, Y, R, R};
  localparam logic [11:0] DG = {G, R, R, R};
  localparam logic [11:0] DY = {Y, R, R, R};
  localparam logic [11:0] RR = {R, R, R, R};

  logic [11:0] lamps;
  assign lamps = {tl_sig_arr[3], tl_sig_arr[2], tl_sig_arr[1], tl_sig_arr[0]};

  main dut (
    .clk        (clk),
    .arstN      (arstN),
    .sensor     (sensor),
    .tl_sig_arr (tl_sig_arr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One reset edge with the given sensors; leaves time 1 unit after that edge
  task automatic do_reset(input logic [3:0] s);
    sensor = s;
    arstN  = 1'b1;
    @(posedge clk);
    #1;
    arstN = 1'b0;
  endtask

  task automatic test_reset();
    sensor = 4'b1111;
    arstN  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (lamps !== AG) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d: got %h want %h", i, lamps, AG);
      end
    end
    arstN = 1'b0;
  endtask

  task automatic test_alternate();
    logic [11:0] ev [0:7];
    int          lv [0:7];
    ev = '{AG, AY, RR, CG, CY, RR, AG, AY};
    lv = '{300, 30, 10, 300, 30, 10, 300, 5};
    do_reset(4'b0101);
    for (int s = 0; s < 8; s++)
      for (int c = 0; c < lv[s]; c++) begin
        n_cmp++;
        if (lamps !== ev[s]) begin
          n_err++;
          $display("FAIL alternate seg %0d cyc %0d: got %h want %h", s, c, lamps, ev[s]);
        end
        @(posedge clk);
        #1;
      end
  endtask

  task automatic test_round_robin();
    logic [11:0] ev [0:12];
    int          lv [0:12];
    ev = '{AG, AY, RR, BG, BY, RR, CG, CY, RR, DG, DY, RR, AG};
    lv = '{300, 30, 10, 300, 30, 10, 300, 30, 10, 300, 30, 10, 20};
    do_reset(4'b1111);
    for (int s = 0; s < 13; s++)
      for (int c = 0; c < lv[s]; c++) begin
        n_cmp++;
        if (lamps !== ev[s]) begin
          n_err++;
          $display("FAIL round_robin seg %0d cyc %0d: got %h want %h", s, c, lamps, ev[s]);
        end
        @(posedge clk);
        #1;
      end
  endtask

  task automatic test_min_green();
    logic [11:0] ev [0:6];
    int          lv [0:6];
    ev = '{AG, AY, RR, BG, BY, RR, CG};
    lv = '{300, 30, 10, 50, 30, 10, 20};
    do_reset(4'b0011);
    for (int s = 0; s < 7; s++)
      for (int c = 0; c < lv[s]; c++) begin
        // B's first green cycle: requests move to A and C
        if (s == 3 && c == 0) sensor = 4'b0101;
        n_cmp++;
        if (lamps !== ev[s]) begin
          n_err++;
          $display("FAIL min_green seg %0d cyc %0d: got %h want %h", s, c, lamps, ev[s]);
        end
        @(posedge clk);
        #1;
      end
  endtask

  task automatic test_idle_hold();
    do_reset(4'b0001);
    for (int c = 0; c < 1200; c++) begin
      n_cmp++;
      if (lamps !== AG) begin
        n_err++;
        $display("FAIL hold_a cyc %0d: got %h want %h", c, lamps, AG);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_idle_empty();
    logic [11:0] ev [0:4];
    int          lv [0:4];
    ev = '{AG, AY, RR, DG, DG};
    lv = '{50, 30, 10, 20, 700};
    do_reset(4'b1000);
    for (int s = 0; s < 5; s++)
      for (int c = 0; c < lv[s]; c++) begin
        if (s == 4 && c == 0) sensor = 4'b0000;
        n_cmp++;
        if (lamps !== ev[s]) begin
          n_err++;
          $display("FAIL empty_hold seg %0d cyc %0d: got %h want %h", s, c, lamps, ev[s]);
        end
        @(posedge clk);
        #1;
      end
  endtask

  task automatic test_reset_mid_yellow();
    logic [11:0] ev [0:4];
    int          lv [0:4];
    ev = '{AG, AY, RR, CG, CG};
    lv = '{50, 30, 10, 10, 40};
    do_reset(4'b0100);
    for (int s = 0; s < 5; s++)
      for (int c = 0; c < lv[s]; c++) begin
        if (s == 4 && c == 0) sensor = 4'b0001;
        n_cmp++;
        if (lamps !== ev[s]) begin
          n_err++;
          $display("FAIL pre_reset seg %0d cyc %0d: got %h want %h", s, c, lamps, ev[s]);
        end
        @(posedge clk);
        #1;
      end
    for (int c = 0; c < 15; c++) begin
      n_cmp++;
      if (lamps !== CY) begin
        n_err++;
        $display("FAIL c_yellow cyc %0d: got %h want %h", c, lamps, CY);
      end
      @(posedge clk);
      #1;
    end
    // Reset mid-yellow: A green again with a fresh counter (full 50-cycle minimum)
    do_reset(4'b0100);
    for (int c = 0; c < 85; c++) begin
      logic [11:0] want;
      want = (c < 50) ? AG : (c < 80) ? AY : RR;
      n_cmp++;
      if (lamps !== want) begin
        n_err++;
        $display("FAIL post_reset cyc %0d: got %h want %h", c, lamps, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    arstN  = 1'b1;
    sensor = 4'b0000;
    test_reset();
    test_alternate();
    test_round_robin();
    test_min_green();
    test_idle_hold();
    test_idle_empty();
    test_reset_mid_yellow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
